// File: rtl/ultra_sensor_array_pkg.sv
// Shared types and helpers for the ultrasonic ranging controller.
package ultra_pkg;

   typedef enum logic [2:0] {
      IDLE,
      TRIG,
      WAIT_RISE,
      MEASURE,
      GAP
   } state_t;

   // Bits needed to hold values 0..v-1.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 63; i++)
         if ((longint'(1) << i) < longint'(v)) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/ultra_sensor_array_if.sv
// Sensor pins plus measurement result bus of the ultrasonic ranging controller.
interface ultra_sensor_array_if #(
   parameter int N_CH  = 4,
   parameter int CNT_W = 21
);
   logic [N_CH-1:0]  ch_en;
   logic [N_CH-1:0]  echo;
   logic [N_CH-1:0]  trig;
   logic [N_CH-1:0]  obj_det;
   logic             meas_valid;
   logic [3:0]       meas_ch;
   logic [CNT_W-1:0] meas_cnt;
   logic             meas_timeout;
   logic             busy;

   modport master (
      input  ch_en, echo,
      output trig, obj_det, meas_valid, meas_ch, meas_cnt, meas_timeout, busy
   );

   modport slave (
      output ch_en, echo,
      input  trig, obj_det, meas_valid, meas_ch, meas_cnt, meas_timeout, busy
   );
endinterface

// File: rtl/ultra_sensor_array_echo_sync.sv
// Two-flop synchroniser for one asynchronous echo pin, with rise/fall strobes.
module ultra_echo_sync (
   input  logic clk,
   input  logic rst,
   input  logic echo,
   output logic rise,
   output logic fall
);
   logic s1, s2, s3;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= echo;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise = s2 & ~s3;
   assign fall = ~s2 & s3;
endmodule

// File: rtl/ultra_sensor_array.sv
// Round-robin HC-SR04 controller: one trigger per frame, echo width timing,
// per-channel object-detect flags with hysteresis.
module ultra_sensor_array
   import ultra_pkg::*;
#(
   parameter int N_CH        = 4,
   parameter int TRIG_CYC    = 500,
   parameter int PERIOD_CYC  = 1900000,
   parameter int TIMEOUT_CYC = 1500000,
   parameter int THRESH_CYC  = 29070,
   parameter int HYST_CYC    = 1450,
   parameter int CNT_W       = 21
) (
   input logic                  clk,
   input logic                  rst,
   ultra_sensor_array_if.master bus
);
   state_t           state, state_nxt;
   logic [3:0]       ch, ptr, base, sel;
   logic [4:0]       j;
   logic             sel_ok, go, fin, fin_to;
   logic [CNT_W-1:0] frame_cnt, wcnt, res_cnt;
   logic [15:0]      en16, rise16, fall16, det, det_nxt;
   logic [N_CH-1:0]  echo_v, rise_v, fall_v, trig_v;

   assign echo_v = bus.echo;

   for (genvar g = 0; g < N_CH; g++) begin : g_sync
      ultra_echo_sync u_sync (
         .clk  (clk),
         .rst  (rst),
         .echo (echo_v[g]),
         .rise (rise_v[g]),
         .fall (fall_v[g])
      );
   end

   assign en16   = 16'(bus.ch_en);
   assign rise16 = 16'(rise_v);
   assign fall16 = 16'(fall_v);

   // From GAP the search starts after the channel just served, else at the pointer.
   always_comb begin
      base   = (state == GAP) ? ((ch == 4'(N_CH - 1)) ? 4'd0 : ch + 4'd1) : ptr;
      sel    = base;
      sel_ok = 1'b0;
      j      = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         j = {1'b0, base} + 5'(i);
         if (j >= 5'(N_CH)) j = j - 5'(N_CH);
         if (en16[j[3:0]]) begin
            sel    = j[3:0];
            sel_ok = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      go        = 1'b0;
      fin       = 1'b0;
      fin_to    = 1'b0;
      res_cnt   = wcnt;
      case (state)
         IDLE:
            if (sel_ok) begin
               state_nxt = TRIG;
               go        = 1'b1;
            end
         TRIG:
            if (frame_cnt >= CNT_W'(TRIG_CYC - 1)) state_nxt = WAIT_RISE;
         WAIT_RISE:
            if (rise16[ch]) begin
               state_nxt = MEASURE;
            end else if (wcnt >= CNT_W'(TIMEOUT_CYC - 1)) begin
               state_nxt = GAP;
               fin       = 1'b1;
               fin_to    = 1'b1;
               res_cnt   = CNT_W'(TIMEOUT_CYC);
            end
         MEASURE:
            if (fall16[ch]) begin
               state_nxt = GAP;
               fin       = 1'b1;
            end else if (wcnt >= CNT_W'(TIMEOUT_CYC - 1)) begin
               state_nxt = GAP;
               fin       = 1'b1;
               fin_to    = 1'b1;
               res_cnt   = CNT_W'(TIMEOUT_CYC);
            end
         GAP:
            if (frame_cnt >= CNT_W'(PERIOD_CYC - 1)) begin
               state_nxt = sel_ok ? TRIG : IDLE;
               go        = sel_ok;
            end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      det_nxt = det;
      if (fin) begin
         if (fin_to)                                         det_nxt[ch] = 1'b0;
         else if (res_cnt < CNT_W'(THRESH_CYC))              det_nxt[ch] = 1'b1;
         else if (res_cnt >= CNT_W'(THRESH_CYC + HYST_CYC))  det_nxt[ch] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ch               <= '0;
         ptr              <= '0;
         frame_cnt        <= '0;
         wcnt             <= '0;
         det              <= '0;
         bus.meas_valid   <= 1'b0;
         bus.meas_ch      <= '0;
         bus.meas_cnt     <= '0;
         bus.meas_timeout <= 1'b0;
      end else begin
         bus.meas_valid <= fin;
         if (go) begin
            ch        <= sel;
            frame_cnt <= '0;
         end else if (state != IDLE && frame_cnt != '1) begin
            frame_cnt <= frame_cnt + 1'b1;
         end
         case (state)
            TRIG:      wcnt <= '0;
            WAIT_RISE: wcnt <= rise16[ch] ? CNT_W'(1) : wcnt + 1'b1;
            MEASURE:   if (wcnt != '1) wcnt <= wcnt + 1'b1;
            default:   wcnt <= wcnt;
         endcase
         if (state == GAP && state_nxt != GAP) ptr <= base;
         if (fin) begin
            bus.meas_ch      <= ch;
            bus.meas_cnt     <= res_cnt;
            bus.meas_timeout <= fin_to;
         end
         // Disabled channels lose their flag one cycle after the enable drops.
         det <= det_nxt & en16;
      end
   end

   always_comb begin
      trig_v = '0;
      for (int i = 0; i < N_CH; i++)
         trig_v[i] = (state == TRIG) && (ch == 4'(i));
   end

   assign bus.trig    = trig_v;
   assign bus.obj_det = det[N_CH-1:0];
   assign bus.busy    = (state != IDLE);

   always_ff @(posedge clk)
      if (!rst)
         assert (CNT_W >= clog2(PERIOD_CYC + 1))
         else $error("CNT_W too narrow for PERIOD_CYC");
endmodule
